// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel pipeline sequencer: FSM states, stage phases
// within a word slot, and the number of flush slots after the last pop.
package sobel_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } seqState_t;

   localparam int PH_POP   = 0;
   localparam int PH_SHIFT = 1;
   localparam int PH_HOLD  = 2;
   localparam int PH_POST  = 3;

   localparam int DRAIN_SLOTS = 2;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cntWidth(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sobel_addr_gen.sv
// Row/word walker for the Sobel sequencer: produces the SRAM word address of the
// current pop and flags the final word slot and the prefetch slot.
module sobel_addr_gen
   import sobel_pkg::*;
#(
   parameter int IMG_W        = 512,
   parameter int IMG_H        = 512,
   parameter int PIX_PER_WORD = 8,
   parameter int ROW_STEP     = 2,
   parameter int PREFETCH_ROW = 410,
   parameter int ADDR_W       = 20
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              advance,
   output logic [ADDR_W-1:0] read_addr,
   output logic              lastSlot,
   output logic              prefetchHit
);

   localparam int WPR      = IMG_W / PIX_PER_WORD;
   localparam int LAST_ROW = IMG_H - 4;
   localparam int WORD_W   = cntWidth(WPR);
   localparam int ROW_W    = cntWidth(IMG_H + 1);
   localparam bit PF_VALID = (PREFETCH_ROW >= 0) && (PREFETCH_ROW <= LAST_ROW) &&
                             (PREFETCH_ROW % ROW_STEP == 0);

   if (IMG_H < 4 || ((IMG_H - 4) % ROW_STEP) != 0) begin : gBadRows
      $error("IMG_H-4 must be a non-negative multiple of ROW_STEP");
   end

   logic [WORD_W-1:0] word;
   logic [ROW_W-1:0]  row;
   logic [ADDR_W-1:0] rowBase;
   logic              wordWrap;

   assign wordWrap = (word == WORD_W'(WPR - 1));

   // rowBase tracks row*WPR incrementally so no multiplier is needed.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         word    <= '0;
         row     <= '0;
         rowBase <= '0;
      end else if (advance) begin
         if (wordWrap) begin
            word    <= '0;
            row     <= row + ROW_W'(ROW_STEP);
            rowBase <= rowBase + ADDR_W'(ROW_STEP * WPR);
         end else begin
            word <= word + WORD_W'(1);
         end
      end
   end

   always_comb begin
      read_addr   = rowBase + ADDR_W'(word);
      lastSlot    = wordWrap && (row == ROW_W'(LAST_ROW));
      prefetchHit = PF_VALID && (row == ROW_W'(PREFETCH_ROW)) && (word == '0);
   end

endmodule

// File: rtl/sobel_pipe_sequencer.sv
// Frame sequencer for the Sobel datapath: walks word slots of PHASE_LEN cycles,
// firing buffer/shifter/hold/multiplier/post enables, then flushes and signals done.
module sobel_pipe_sequencer
   import sobel_pkg::*;
#(
   parameter int IMG_W        = 512,
   parameter int IMG_H        = 512,
   parameter int PIX_PER_WORD = 8,
   parameter int ROW_STEP     = 2,
   parameter int PHASE_LEN    = 8,
   parameter int PREFETCH_ROW = 410,
   parameter int ADDR_W       = 20
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_en,
   input  logic              stall,
   output logic              pop_en,
   output logic              shift_en,
   output logic              hold_en,
   output logic              mult_en,
   output logic              post_en,
   output logic [ADDR_W-1:0] read_addr,
   output logic              get_next,
   output logic              busy,
   output logic              done
);

   localparam int WPR  = IMG_W / PIX_PER_WORD;
   localparam int PH_W = cntWidth(PHASE_LEN);
   localparam int DR_W = cntWidth(DRAIN_SLOTS);

   if (PHASE_LEN < 4) begin : gBadPhase
      $error("PHASE_LEN must be at least 4");
   end
   if (longint'(IMG_H) * longint'(WPR) > (longint'(1) << ADDR_W)) begin : gBadAddr
      $error("IMG_H*WPR does not fit in ADDR_W bits");
   end

   seqState_t       state;
   logic [PH_W-1:0] phase;
   logic [DR_W-1:0] drainSlot;
   logic            phaseWrap;
   logic            lastSlot;
   logic            prefetchHit;
   logic            inFrame;
   logic            go;
   logic            addrClear;
   logic            addrAdvance;

   assign phaseWrap = (phase == PH_W'(PHASE_LEN - 1));
   assign inFrame   = (state == ST_RUN) || (state == ST_DRAIN);
   assign go        = !stall;

   // The final slot leaves the counters parked so read_addr holds through DRAIN.
   assign addrClear   = (state == ST_IDLE) && start_en;
   assign addrAdvance = (state == ST_RUN) && go && phaseWrap && !lastSlot;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         phase     <= '0;
         drainSlot <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               phase     <= '0;
               drainSlot <= '0;
               if (start_en) state <= ST_RUN;
            end
            ST_RUN: if (go) begin
               phase <= phaseWrap ? '0 : phase + PH_W'(1);
               if (phaseWrap && lastSlot) begin
                  state     <= ST_DRAIN;
                  drainSlot <= '0;
               end
            end
            ST_DRAIN: if (go) begin
               phase <= phaseWrap ? '0 : phase + PH_W'(1);
               if (phaseWrap) begin
                  if (drainSlot == DR_W'(DRAIN_SLOTS - 1)) state <= ST_DONE;
                  else drainSlot <= drainSlot + DR_W'(1);
               end
            end
            ST_DONE: if (go) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Stall gates the decode directly so a frozen phase never re-fires its enable.
   always_comb begin
      pop_en   = go && (state == ST_RUN) && (phase == PH_W'(PH_POP));
      shift_en = go && inFrame && (phase == PH_W'(PH_SHIFT));
      hold_en  = go && inFrame && (phase == PH_W'(PH_HOLD));
      mult_en  = hold_en;
      post_en  = go && inFrame && (phase == PH_W'(PH_POST));
      get_next = pop_en && prefetchHit;
      busy     = inFrame;
      done     = go && (state == ST_DONE);
   end

   sobel_addr_gen #(
      .IMG_W       (IMG_W),
      .IMG_H       (IMG_H),
      .PIX_PER_WORD(PIX_PER_WORD),
      .ROW_STEP    (ROW_STEP),
      .PREFETCH_ROW(PREFETCH_ROW),
      .ADDR_W      (ADDR_W)
   ) uAddrGen (
      .clk        (clk),
      .reset      (reset),
      .clear      (addrClear),
      .advance    (addrAdvance),
      .read_addr  (read_addr),
      .lastSlot   (lastSlot),
      .prefetchHit(prefetchHit)
   );

endmodule

// File: tb/tb_sobel_pipe_sequencer.sv
// Bench for sobel_pipe_sequencer: a per-frame timeline of expected outputs is
// consumed one entry per unstalled cycle and compared against the DUT every cycle.
module tb_sobel_pipe_sequencer;

   localparam int IMG_W = 32, IMG_H = 8, PPW = 8, RSTEP = 2, PL = 8, PF = 4, AW = 20;
   localparam int WPR = IMG_W / PPW;

   logic          clk = 1'b0;
   logic          reset, start_en, stall;
   logic          pop_en, shift_en, hold_en, mult_en, post_en, get_next, busy, done;
   logic [AW-1:0] read_addr;

   always #5 clk = ~clk;

   sobel_pipe_sequencer #(
      .IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_PER_WORD(PPW), .ROW_STEP(RSTEP),
      .PHASE_LEN(PL), .PREFETCH_ROW(PF), .ADDR_W(AW)
   ) dut (
      .clk(clk), .reset(reset), .start_en(start_en), .stall(stall),
      .pop_en(pop_en), .shift_en(shift_en), .hold_en(hold_en), .mult_en(mult_en),
      .post_en(post_en), .read_addr(read_addr), .get_next(get_next),
      .busy(busy), .done(done)
   );

   typedef struct packed {
      logic          pop, shift, hold, mult, post, gnext, busy, done;
      logic [AW-1:0] addr;
   } obs_t;

   obs_t          tl[$];
   int            idx;
   bit            running;
   logic [AW-1:0] lastAddr;
   int            total = 0, bad = 0;
   int            cyc, doneAt, doneCnt, gnAt, gnCnt, popCnt, lastPopAt;
   logic [AW-1:0] gnAddr;

   function automatic obs_t slotRec(input int ph, input bit allowPop, input int a, input bit pfRow);
      obs_t r;
      r       = '0;
      r.busy  = 1'b1;
      r.addr  = AW'(a);
      r.pop   = allowPop && (ph == 0);
      r.shift = (ph == 1);
      r.hold  = (ph == 2);
      r.mult  = (ph == 2);
      r.post  = (ph == 3);
      r.gnext = r.pop && pfRow;
      return r;
   endfunction

   task automatic buildFrame();
      obs_t r;
      int   a;
      tl.delete();
      a = 0;
      for (int row = 0; row <= IMG_H - 4; row += RSTEP)
         for (int w = 0; w < WPR; w++) begin
            a = row * WPR + w;
            for (int ph = 0; ph < PL; ph++) tl.push_back(slotRec(ph, 1'b1, a, (row == PF) && (w == 0)));
         end
      for (int s = 0; s < 2; s++)
         for (int ph = 0; ph < PL; ph++) tl.push_back(slotRec(ph, 1'b0, a, 1'b0));
      r      = '0;
      r.done = 1'b1;
      r.addr = AW'(a);
      tl.push_back(r);
   endtask

   task automatic clearEv();
      cyc = 0; doneAt = -1; doneCnt = 0; gnAt = -1; gnCnt = 0; popCnt = 0; lastPopAt = -1; gnAddr = '0;
   endtask

   task automatic check(input string tag, input int got, input int want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s: got %0d want %0d", tag, got, want);
      end
   endtask

   task automatic step(input logic st, input logic sl, input logic rs);
      obs_t obs, exp;
      start_en = st; stall = sl; reset = rs;
      #1;
      obs = {pop_en, shift_en, hold_en, mult_en, post_en, get_next, busy, done, read_addr};
      if (running) exp = tl[idx];
      else begin
         exp      = '0;
         exp.addr = lastAddr;
      end
      if (sl) begin
         exp.pop = 0; exp.shift = 0; exp.hold = 0; exp.mult = 0;
         exp.post = 0; exp.gnext = 0; exp.done = 0;
      end
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL cycle%0d outputs: got %h want %h", cyc, obs, exp);
      end
      if (done === 1'b1) begin doneCnt++; doneAt = cyc; end
      if (get_next === 1'b1) begin gnCnt++; gnAt = cyc; gnAddr = read_addr; end
      if (pop_en === 1'b1) begin popCnt++; lastPopAt = cyc; end
      // advance the reference across the coming clock edge
      if (rs) begin
         running  = 0;
         lastAddr = '0;
      end else if (!running) begin
         if (st) begin
            buildFrame();
            running = 1;
            idx     = 0;
         end
      end else if (!sl) begin
         idx++;
         if (idx == tl.size()) begin
            running  = 0;
            lastAddr = tl[tl.size()-1].addr;
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; start_en = 1'b0; stall = 1'b0;
      running = 0; lastAddr = '0; idx = 0;
      clearEv();
      repeat (2) @(posedge clk);
      @(negedge clk);
      step(0, 0, 1);
      step(0, 0, 1);

      // nominal frame
      clearEv();
      step(1, 0, 0);
      repeat (124) step(0, 0, 0);
      check("nominal pops", popCnt, 12);
      check("nominal last pop", lastPopAt, 89);
      check("nominal done cycle", doneAt, 113);
      check("nominal done count", doneCnt, 1);
      check("nominal get_next cycle", gnAt, 65);
      check("nominal get_next count", gnCnt, 1);
      check("nominal get_next addr", int'(gnAddr), 16);

      // stall window 20..29
      clearEv();
      for (int c = 0; c < 135; c++) step(c == 0, (c >= 20) && (c <= 29), 0);
      check("stall done cycle", doneAt, 123);
      check("stall last pop", lastPopAt, 99);
      check("stall get_next cycle", gnAt, 75);
      check("stall pops", popCnt, 12);

      // reset mid-run, then restart
      clearEv();
      for (int c = 0; c < 62; c++) step((c == 0) || (c == 60), 0, c == 50);
      check("abort done count", doneCnt, 0);
      check("abort get_next count", gnCnt, 0);
      check("restart first pop", lastPopAt, 61);
      check("restart addr", int'(read_addr), 0);
      repeat (115) step(0, 0, 0);
      check("restart done count", doneCnt, 1);

      // start re-pulse during RUN is ignored
      clearEv();
      for (int c = 0; c < 125; c++) step((c == 0) || (c == 30), 0, 0);
      check("repulse done cycle", doneAt, 113);
      check("repulse pops", popCnt, 12);
      check("repulse done count", doneCnt, 1);

      // random start/stall/reset traffic
      for (int n = 0; n < 2500; n++)
         step($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 299) == 0);
      repeat (150) step(0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sobel_pipe_sequencer.md
SOBEL_PIPE_SEQUENCER -- requirements
Module: sobel_pipe_sequencer

Interface
REQ-001 Parameter IMG_W, default 512: image width in pixels.
REQ-002 Parameter IMG_H, default 512: image height in rows.
REQ-003 Parameter PIX_PER_WORD, default 8: pixels per SRAM word; WPR = IMG_W/PIX_PER_WORD words per row.
REQ-004 Parameter ROW_STEP, default 2: rows advanced per row pass.
REQ-005 Parameter PHASE_LEN, default 8: cycles per word slot; legal minimum 4.
REQ-006 Parameter PREFETCH_ROW, default 410: row at which the next-frame request fires.
REQ-007 Parameter ADDR_W, default 20: read address width.
REQ-008 Reset and clock: reset, synchronous, active-high; clock clk.
REQ-009 clk  in  1  clock.
REQ-010 reset  in  1  synchronous active-high reset.
REQ-011 start_en  in  1  frame start request, sampled in IDLE only.
REQ-012 stall  in  1  freezes sequencing while high.
REQ-013 pop_en, shift_en, hold_en, mult_en, post_en  out  1 each  one-cycle stage enables (buffer, shifter, hold, multiplier, mag/dir).
REQ-014 read_addr  out  ADDR_W  word address of the current pop.
REQ-015 get_next  out  1  one-cycle next-frame fill request.
REQ-016 busy  out  1  high in RUN and DRAIN.
REQ-017 done  out  1  one-cycle frame-complete pulse.

Function
REQ-018 States: IDLE, RUN, DRAIN, DONE.
REQ-019 IDLE->RUN on the cycle start_en=1 is sampled; phase counter, word index and row counter cleared to 0.
REQ-020 Phase counter counts 0..PHASE_LEN-1 and wraps, in RUN and DRAIN only.
REQ-021 RUN schedule per word slot: phase 0 pop_en, phase 1 shift_en, phase 2 hold_en and mult_en, phase 3 post_en; all other cycles enables low.
REQ-022 read_addr = row*WPR + word, valid during the pop_en cycle, held otherwise.
REQ-023 Word index advances on phase wrap; at WPR-1 it wraps to 0 and row advances by ROW_STEP (skipped rows never addressed).
REQ-024 Last row pass starts at row IMG_H-4; RUN->DRAIN on phase wrap after the final word slot.
REQ-025 DRAIN lasts exactly 2 word slots (2*PHASE_LEN cycles), pop_en held low, phases 1-3 enables still issued for pipeline flush.
REQ-026 DRAIN->DONE; DONE asserts done for one cycle, then ->IDLE.
REQ-027 get_next pulses exactly once per frame, coincident with the pop_en of row PREFETCH_ROW word 0; never fires if PREFETCH_ROW is not a visited row.
REQ-028 stall=1: phase counter, word, row and state frozen; all enables, get_next and done forced low; resumes at the frozen phase on stall=0.
REQ-029 start_en while not IDLE ignored; start_en and stall together in IDLE: transition occurs, first pop deferred until stall=0.
REQ-030 Address arithmetic computed at ADDR_W bits; elaboration error if IMG_H*WPR > 2^ADDR_W.

Reset
REQ-031 reset forces IDLE; all counters 0; every output 0 (read_addr 0), on the next clk edge.
REQ-032 reset mid-RUN or mid-DRAIN aborts the frame with no done or get_next pulse; reset has priority over start_en and stall.

Structure
REQ-033 Shared package sobel_pkg holds the state enum, the stage-phase constants (0..3) and the DRAIN slot count.
REQ-034 Row/word counting and read_addr generation live in sub-module sobel_addr_gen; the FSM and enable decoder stay in the top.

Verification (IMG_W=32, IMG_H=8, PIX_PER_WORD=8, ROW_STEP=2, PHASE_LEN=8, PREFETCH_ROW=4)
REQ-035 start_en pulse at cycle 0 -> pop_en at cycles 1,9,...,89 with read_addr 0,1,2,3,8,9,10,11,16,17,18,19.
REQ-036 Same run -> shift_en at pop+1, hold_en/mult_en at pop+2, post_en at pop+3; done single pulse at cycle 113; busy high cycles 1..112.
REQ-037 Same run -> get_next single pulse at cycle 65 (read_addr 16); none elsewhere.
REQ-038 stall high cycles 20-29 -> all pops after cycle 17 shifted by 10 cycles, done at cycle 123, no enables during stall.
REQ-039 reset at cycle 50 -> all outputs 0 from cycle 51, no done; new start_en at cycle 60 -> read_addr 0 pop at cycle 61.
REQ-040 start_en re-pulsed at cycle 30 during RUN -> waveform identical to REQ-035/036.
